// File: rtl/bram_wr.sv
// bram_wr: packs 16-bit samples in pairs and bursts WR_LEN words into a BRAM port.
// Optional macro BRAM_WR_STATUS_EN appends a status write (WR_LEN) at STATUS_ADDR.
module bram_wr #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WR_LEN      = 256,
    parameter logic [31:0] STATUS_ADDR = 32'h0000_FFFC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_wr,
    input  logic        din_valid,
    input  logic [15:0] din,
    output logic        din_ready,
    output logic        busy,
    output logic        done,
    output logic        ram_clk,
    output logic        ram_en,
    output logic [3:0]  ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wr_data,
    output logic        ram_rst
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL_LO,
        S_FILL_HI,
        S_WRITE,
`ifdef BRAM_WR_STATUS_EN
        S_STATUS,
`endif
        S_DONE
    } state_t;

    localparam logic [15:0] LAST = 16'(WR_LEN - 1);

    state_t      r_state, w_state_nx;
    logic        r_start_d0, r_start_d1;
    logic        w_pos_start, w_acc;
    logic [15:0] r_wcnt, w_wcnt_nx;
    logic [15:0] r_lo, w_lo_nx;
    logic        r_busy, w_busy_nx;
    logic        r_rdy, w_rdy_nx;
    logic        r_done, w_done_nx;
    logic        r_en, w_en_nx;
    logic [3:0]  r_we, w_we_nx;
    logic [31:0] r_addr, w_addr_nx;
    logic [31:0] r_data, w_data_nx;

    assign w_pos_start = r_start_d0 & ~r_start_d1;
    assign w_acc       = din_valid & r_rdy;

    always_comb begin
        w_state_nx = r_state;
        w_wcnt_nx  = r_wcnt;
        w_lo_nx    = r_lo;
        w_busy_nx  = r_busy;
        w_rdy_nx   = r_rdy;
        w_done_nx  = r_done;
        w_en_nx    = r_en;
        w_we_nx    = r_we;
        w_addr_nx  = r_addr;
        w_data_nx  = r_data;
        unique case (r_state)
            S_IDLE: begin
                if (w_pos_start) begin
                    w_wcnt_nx  = '0;
                    w_busy_nx  = 1'b1;
                    w_rdy_nx   = 1'b1;
                    w_state_nx = S_FILL_LO;
                end
            end
            S_FILL_LO: begin
                if (w_acc) begin
                    w_lo_nx    = din;
                    w_state_nx = S_FILL_HI;
                end
            end
            S_FILL_HI: begin
                if (w_acc) begin
                    w_en_nx    = 1'b1;
                    w_we_nx    = 4'hF;
                    w_addr_nx  = BASE_ADDR + {14'd0, r_wcnt, 2'b00};
                    w_data_nx  = {din, r_lo};
                    w_rdy_nx   = 1'b0;
                    w_state_nx = S_WRITE;
                end
            end
            S_WRITE: begin
                w_en_nx = 1'b0;
                w_we_nx = 4'h0;
                if (r_wcnt == LAST) begin
`ifdef BRAM_WR_STATUS_EN
                    w_en_nx    = 1'b1;
                    w_we_nx    = 4'hF;
                    w_addr_nx  = STATUS_ADDR;
                    w_data_nx  = 32'(WR_LEN);
                    w_state_nx = S_STATUS;
`else
                    w_done_nx  = 1'b1;
                    w_busy_nx  = 1'b0;
                    w_addr_nx  = BASE_ADDR;
                    w_state_nx = S_DONE;
`endif
                end else begin
                    w_wcnt_nx  = r_wcnt + 16'd1;
                    w_rdy_nx   = 1'b1;
                    w_state_nx = S_FILL_LO;
                end
            end
`ifdef BRAM_WR_STATUS_EN
            S_STATUS: begin
                w_en_nx    = 1'b0;
                w_we_nx    = 4'h0;
                w_done_nx  = 1'b1;
                w_busy_nx  = 1'b0;
                w_addr_nx  = BASE_ADDR;
                w_state_nx = S_DONE;
            end
`endif
            S_DONE: begin
                // done is visible for exactly this state's cycle
                w_done_nx  = 1'b0;
                w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_start_d0 <= 1'b0;
            r_start_d1 <= 1'b0;
            r_wcnt     <= '0;
            r_lo       <= '0;
            r_busy     <= 1'b0;
            r_rdy      <= 1'b0;
            r_done     <= 1'b0;
            r_en       <= 1'b0;
            r_we       <= 4'h0;
            r_addr     <= BASE_ADDR;
            r_data     <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_start_d0 <= start_wr;
            r_start_d1 <= r_start_d0;
            r_wcnt     <= w_wcnt_nx;
            r_lo       <= w_lo_nx;
            r_busy     <= w_busy_nx;
            r_rdy      <= w_rdy_nx;
            r_done     <= w_done_nx;
            r_en       <= w_en_nx;
            r_we       <= w_we_nx;
            r_addr     <= w_addr_nx;
            r_data     <= w_data_nx;
        end
    end

    assign din_ready   = r_rdy;
    assign busy        = r_busy;
    assign done        = r_done;
    assign ram_clk     = clk;
    assign ram_en      = r_en;
    assign ram_we      = r_we;
    assign ram_addr    = r_addr;
    assign ram_wr_data = r_data;
    assign ram_rst     = 1'b0;

endmodule

// File: tb/tb_bram_wr.sv
// tb_bram_wr: cycle table for a WR_LEN=1 instance plus randomized bursts
// on a WR_LEN=4 instance checked against a sample-pairing scoreboard.
module tb_bram_wr;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam logic [31:0] STAT = 32'h0000_FFFC;
    localparam int          LEN  = 4;
`ifdef BRAM_WR_STATUS_EN
    localparam int NSTAT = 1;
`else
    localparam int NSTAT = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start_wr = 1'b0, din_valid = 1'b0;
    logic [15:0] din = '0;
    logic        din_ready, busy, done, ram_clk, ram_en, ram_rst;
    logic [3:0]  ram_we;
    logic [31:0] ram_addr, ram_wr_data;

    logic        s1_start = 1'b0, s1_valid = 1'b0;
    logic [15:0] s1_din = '0;
    logic        s1_ready, s1_busy, s1_done, s1_ram_clk, s1_en, s1_ram_rst;
    logic [3:0]  s1_we;
    logic [31:0] s1_addr, s1_data;

    bram_wr #(.BASE_ADDR(BASE), .WR_LEN(LEN), .STATUS_ADDR(STAT)) u_dut (
        .clk(clk), .rst(rst), .start_wr(start_wr), .din_valid(din_valid),
        .din(din), .din_ready(din_ready), .busy(busy), .done(done),
        .ram_clk(ram_clk), .ram_en(ram_en), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wr_data(ram_wr_data), .ram_rst(ram_rst)
    );

    bram_wr #(.BASE_ADDR(BASE), .WR_LEN(1), .STATUS_ADDR(STAT)) u_dut1 (
        .clk(clk), .rst(rst), .start_wr(s1_start), .din_valid(s1_valid),
        .din(s1_din), .din_ready(s1_ready), .busy(s1_busy), .done(s1_done),
        .ram_clk(s1_ram_clk), .ram_en(s1_en), .ram_we(s1_we),
        .ram_addr(s1_addr), .ram_wr_data(s1_data), .ram_rst(s1_ram_rst)
    );

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        int          t;
    } wr_t;

    wr_t obs[$];
    int  cyc = 0, done_cnt = 0, done_t = 0, dbl_done = 0;
    int  bad_rst_wr = 0, bad_we = 0;
    logic prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            prev_done = 1'b0;
            if (ram_en !== 1'b0) bad_rst_wr++;
        end else begin
            if (ram_en === 1'b1) begin
                obs.push_back('{ram_addr, ram_wr_data, cyc});
                if (ram_we !== 4'hF) bad_we++;
            end else if (ram_we !== 4'h0) bad_we++;
            if (done === 1'b1) begin
                done_cnt++;
                done_t = cyc;
                if (prev_done) dbl_done++;
            end
            prev_done = done;
        end
    end

    // Reference: word i is the (2i)th sample low and (2i+1)th high at BASE+4i.
    task automatic check_writes(input string tag, input logic [15:0] s[$], input bit timing);
        chk($sformatf("%s_wr_count", tag), obs.size(), LEN + NSTAT);
        for (int i = 0; i < LEN && i < obs.size(); i++)
            chk($sformatf("%s_wr%0d", tag, i), {obs[i].a, obs[i].d},
                {BASE + 32'(4 * i), s[2*i+1], s[2*i]});
`ifdef BRAM_WR_STATUS_EN
        if (obs.size() > LEN)
            chk($sformatf("%s_status", tag), {obs[LEN].a, obs[LEN].d},
                {STAT, 32'(LEN)});
`endif
        if (timing && obs.size() >= LEN) begin
            for (int i = 1; i < LEN; i++)
                chk($sformatf("%s_gap%0d", tag, i), obs[i].t - obs[i-1].t, 3);
            chk($sformatf("%s_done_lat", tag), done_t - obs[LEN-1].t, 1 + NSTAT);
        end
    endtask

    task automatic run_burst(input string tag, input logic [15:0] s[$],
                             input int vpct, input bit hold, input bit timing);
        int   idx, budget, t;
        bit   tog;
        logic rdy;
        obs.delete();
        done_cnt = 0;
        dbl_done = 0;
        start_wr = 1'b1;
        din_valid = 1'b0;
        @(posedge clk); #1;
        chk($sformatf("%s_busy_e0", tag), busy, 1'b0);
        @(posedge clk); #1;
        chk($sformatf("%s_busy_rdy_e1", tag), {busy, din_ready}, 2'b11);
        if (!hold) start_wr = 1'b0;
        idx = 0;
        budget = 0;
        tog = 1'b0;
        while (idx < 2 * LEN && budget < 500) begin
            din_valid = ($urandom_range(99) < vpct);
            din = s[idx];
            if (hold) begin
                if (idx == 3 && !tog) begin
                    start_wr = 1'b0;
                    tog = 1'b1;
                end else start_wr = 1'b1;
            end
            rdy = din_ready;
            @(posedge clk); #1;
            budget++;
            if (din_valid && rdy) idx++;
        end
        din_valid = 1'b0;
        chk($sformatf("%s_samples_fed", tag), idx, 2 * LEN);
        t = 0;
        while (done_cnt == 0 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk($sformatf("%s_done_once", tag), done_cnt, 1);
        chk($sformatf("%s_done_width", tag), dbl_done, 0);
        chk($sformatf("%s_busy_after", tag), busy, 1'b0);
        check_writes(tag, s, timing);
    endtask

    typedef struct {
        logic        st;
        logic        v;
        logic [15:0] d;
        logic [79:0] exp;
    } vec_t;

    function automatic logic [79:0] ov(logic b, logic r, logic dn, logic en,
                                       logic [3:0] we, logic [31:0] a, logic [31:0] dt);
        return {8'd0, b, r, dn, en, we, a, dt};
    endfunction

    initial begin
        vec_t        tbl[$];
        logic [15:0] s[$];
        int          t, idx;
        logic        rdy;

        tbl.push_back('{1'b1, 1'b0, 16'h0000, ov(0, 0, 0, 0, 4'h0, 32'h0, 32'h0)});
        tbl.push_back('{1'b1, 1'b1, 16'hBEEF, ov(1, 1, 0, 0, 4'h0, 32'h0, 32'h0)});
        tbl.push_back('{1'b1, 1'b1, 16'hBEEF, ov(1, 1, 0, 0, 4'h0, 32'h0, 32'h0)});
        tbl.push_back('{1'b0, 1'b1, 16'hCAFE, ov(1, 0, 0, 1, 4'hF, 32'h0, 32'hCAFEBEEF)});
`ifdef BRAM_WR_STATUS_EN
        tbl.push_back('{1'b0, 1'b0, 16'h0000, ov(1, 0, 0, 1, 4'hF, STAT, 32'h1)});
        tbl.push_back('{1'b0, 1'b0, 16'h0000, ov(0, 0, 1, 0, 4'h0, 32'h0, 32'h1)});
        tbl.push_back('{1'b0, 1'b0, 16'h0000, ov(0, 0, 0, 0, 4'h0, 32'h0, 32'h1)});
        tbl.push_back('{1'b1, 1'b0, 16'h0000, ov(0, 0, 0, 0, 4'h0, 32'h0, 32'h1)});
        tbl.push_back('{1'b1, 1'b0, 16'h0000, ov(1, 1, 0, 0, 4'h0, 32'h0, 32'h1)});
`else
        tbl.push_back('{1'b0, 1'b0, 16'h0000, ov(0, 0, 1, 0, 4'h0, 32'h0, 32'hCAFEBEEF)});
        tbl.push_back('{1'b0, 1'b0, 16'h0000, ov(0, 0, 0, 0, 4'h0, 32'h0, 32'hCAFEBEEF)});
        tbl.push_back('{1'b1, 1'b0, 16'h0000, ov(0, 0, 0, 0, 4'h0, 32'h0, 32'hCAFEBEEF)});
        tbl.push_back('{1'b1, 1'b0, 16'h0000, ov(1, 1, 0, 0, 4'h0, 32'h0, 32'hCAFEBEEF)});
`endif

        // reset held with start high
        rst = 1'b1;
        start_wr = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs",
            {ram_en, ram_we, ram_addr, ram_wr_data, din_ready, busy, done, ram_rst},
            {1'b0, 4'h0, BASE, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0});
        chk("reset_outputs_len1", ov(s1_busy, s1_ready, s1_done, s1_en, s1_we, s1_addr, s1_data),
            ov(0, 0, 0, 0, 4'h0, BASE, 32'h0));
        chk("ram_clk_high", ram_clk, clk);
        @(negedge clk);
        chk("ram_clk_low", ram_clk, clk);
        start_wr = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_after_reset", {busy, din_ready, ram_en}, 3'b000);

        for (int i = 0; i < tbl.size(); i++) begin
            s1_start = tbl[i].st;
            s1_valid = tbl[i].v;
            s1_din = tbl[i].d;
            @(posedge clk); #1;
            chk($sformatf("len1_row%0d", i),
                ov(s1_busy, s1_ready, s1_done, s1_en, s1_we, s1_addr, s1_data), tbl[i].exp);
        end

        s = '{16'h0001, 16'h0002, 16'h0003, 16'h0004,
              16'h0005, 16'h0006, 16'h0007, 16'h0008};
        run_burst("basic", s, 100, 1'b0, 1'b1);
        run_burst("bp_fixed", s, 45, 1'b0, 1'b0);

        for (int b = 0; b < 4; b++) begin
            s.delete();
            for (int k = 0; k < 2 * LEN; k++) s.push_back(16'($urandom));
            run_burst($sformatf("rand%0d", b), s, 20 + 20 * b, 1'b0, 1'b0);
        end

        // start toggled mid-burst then held through done
        s.delete();
        for (int k = 0; k < 2 * LEN; k++) s.push_back(16'($urandom));
        run_burst("hold", s, 70, 1'b1, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        chk("hold_no_rerun_busy", busy, 1'b0);
        chk("hold_no_rerun_done", done_cnt, 1);
        chk("hold_no_rerun_wr", obs.size(), LEN + NSTAT);
        start_wr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        s.delete();
        for (int k = 0; k < 2 * LEN; k++) s.push_back(16'($urandom));
        run_burst("after_hold", s, 100, 1'b0, 1'b1);

        // reset after the second write of a burst
        obs.delete();
        done_cnt = 0;
        start_wr = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        start_wr = 1'b0;
        idx = 0;
        t = 0;
        while (obs.size() < 2 && t < 100) begin
            din_valid = 1'b1;
            din = 16'h1000 + 16'(idx);
            rdy = din_ready;
            @(posedge clk); #1;
            t++;
            if (rdy) idx++;
        end
        chk("mid_rst_two_writes", obs.size(), 2);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_outputs",
            {ram_en, ram_we, ram_addr, ram_wr_data, din_ready, busy, done},
            {1'b0, 4'h0, BASE, 32'h0, 1'b0, 1'b0, 1'b0});
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        din_valid = 1'b0;
        chk("mid_rst_no_more_writes", obs.size(), 2);
        chk("mid_rst_no_done", done_cnt, 0);
        s.delete();
        for (int k = 0; k < 2 * LEN; k++) s.push_back(16'($urandom));
        run_burst("post_rst", s, 60, 1'b0, 1'b0);

        chk("no_write_in_reset", bad_rst_wr, 0);
        chk("we_matches_en", bad_we, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
        $fatal(1);
    end

endmodule
